// File: rtl/enc_snap_sched_pkg.sv
// enc_snap_sched_pkg
// Shared constants and types for the encoder snapshot scheduler:
// FSM state encoding, shadow read-select codes, preload reset value,
// copy length and small index helpers.
package enc_snap_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_COPY  = 2'd2,
    ST_SWAP  = 2'd3
  } snapState_e;

  localparam logic [1:0]  RD_QUAD   = 2'd0;
  localparam logic [1:0]  RD_PERD   = 2'd1;
  localparam logic [1:0]  RD_FREQ   = 2'd2;
  localparam logic [1:0]  RD_STATUS = 2'd3;

  localparam int          QUAD_W    = 25;
  localparam int          COPY_LEN  = 12;
  localparam logic [23:0] PRELOAD_DEFAULT = 24'h800000;

  // One-hot strobe for a 2-bit channel number (ch1 = bit 0).
  function automatic logic [3:0] chOneHot(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction

  // Flat word index into a bank: three words per channel (quad, perd, freq).
  function automatic logic [3:0] wordIndex(input logic [1:0] ch, input logic [1:0] sel);
    return ({2'b00, ch} * 4'd3) + {2'b00, sel};
  endfunction

endpackage

// File: rtl/enc_preload_arb.sv
// enc_preload_arb
// Two-requester fixed-priority arbiter onto the single preload/set_enc port.
// Ports:
//   sysclk, reset      clock, synchronous active-low reset
//   hpReq_i/Ch_i/Data_i host preload request (one-cycle pulse, wins ties)
//   axReq_i/Ch_i/Data_i aux preload request (level, held until axAck_o)
//   axAck_o            one-cycle grant to aux, coincident with its strobe
//   setEnc_o           one-hot one-cycle preload strobe
//   preload_o          preload value, held until the next grant
module enc_preload_arb
  import enc_snap_sched_pkg::*;
(
  input  logic        sysclk,
  input  logic        reset,
  input  logic        hpReq_i,
  input  logic [1:0]  hpCh_i,
  input  logic [23:0] hpData_i,
  input  logic        axReq_i,
  input  logic [1:0]  axCh_i,
  input  logic [23:0] axData_i,
  output logic        axAck_o,
  output logic [3:0]  setEnc_o,
  output logic [23:0] preload_o
);

  logic [3:0]  setEnc_q, setEnc_d;
  logic [23:0] preload_q, preload_d;
  logic        axAck_q, axAck_d;

  // Grant decision. Host always wins. Aux is still holding its request in
  // the cycle it sees its ack, so a grant is suppressed while axAck_q is set
  // to avoid issuing the same aux preload twice.
  always_comb begin
    setEnc_d  = '0;
    preload_d = preload_q;
    axAck_d   = 1'b0;
    if (hpReq_i) begin
      setEnc_d  = chOneHot(hpCh_i);
      preload_d = hpData_i;
    end else if (axReq_i && !axAck_q) begin
      setEnc_d  = chOneHot(axCh_i);
      preload_d = axData_i;
      axAck_d   = 1'b1;
    end
  end

  // Registered outputs so the strobe lands the cycle after the request.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      setEnc_q  <= '0;
      preload_q <= PRELOAD_DEFAULT;
      axAck_q   <= 1'b0;
    end else begin
      setEnc_q  <= setEnc_d;
      preload_q <= preload_d;
      axAck_q   <= axAck_d;
    end
  end

  assign setEnc_o  = setEnc_q;
  assign preload_o = preload_q;
  assign axAck_o   = axAck_q;

endmodule

// File: rtl/enc_snap_sched.sv
// enc_snap_sched
// Coherent snapshot sequencer for the four-channel encoder datapath plus the
// preload arbiter. A host or periodic trigger latches all 12 live words in one
// cycle, copies them one per cycle into the inactive half of a double-buffered
// shadow bank, then swaps banks so reads always see a complete sample set.
// Ports:
//   sysclk, reset            clock, synchronous active-low reset
//   quad_in/perd_in/freq_in  live encoder words, ch1 in LSBs
//   host_trig, tmr_period    snapshot triggers (period 0 disables the timer)
//   rd_ch, rd_sel, rd_data   registered shadow read (sel 3 = status word)
//   busy, seq_cnt, ovr_cnt   sequencer status
//   hp_*, ax_*, set_enc, preload  preload arbitration
module enc_snap_sched
  import enc_snap_sched_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int TMR_W = 24,
  parameter int SEQ_W = 16
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic [NCH*QUAD_W-1:0] quad_in,
  input  logic [NCH*32-1:0]     perd_in,
  input  logic [NCH*32-1:0]     freq_in,
  input  logic                  host_trig,
  input  logic [TMR_W-1:0]      tmr_period,
  input  logic [1:0]            rd_ch,
  input  logic [1:0]            rd_sel,
  output logic [31:0]           rd_data,
  output logic                  busy,
  output logic [SEQ_W-1:0]      seq_cnt,
  output logic [7:0]            ovr_cnt,
  input  logic                  hp_req,
  input  logic [1:0]            hp_ch,
  input  logic [23:0]           hp_data,
  input  logic                  ax_req,
  input  logic [1:0]            ax_ch,
  input  logic [23:0]           ax_data,
  output logic                  ax_ack,
  output logic [3:0]            set_enc,
  output logic [23:0]           preload
);

  snapState_e       state_q, state_d;
  logic [3:0]       copyIdx_q, copyIdx_d;
  logic             pending_q, pending_d;
  logic [7:0]       ovrCnt_q, ovrCnt_d;
  logic [SEQ_W-1:0] seqCnt_q;
  logic             activeBank_q;
  logic [TMR_W-1:0] tmrCnt_q, tmrCnt_d;
  logic             tmrTrig;
  logic             trig;
  logic [31:0]      stage_q [COPY_LEN];
  logic [31:0]      bank_q  [2][COPY_LEN];
  logic [31:0]      rdData_q;
  logic [31:0]      statusWord;

  // Periodic timer: wraps at tmr_period-1 and fires a one-cycle trigger.
  // The >= compare recovers cleanly if the period is lowered mid-count.
  always_comb begin
    tmrCnt_d = '0;
    tmrTrig  = 1'b0;
    if (tmr_period != '0) begin
      if (tmrCnt_q >= tmr_period - TMR_W'(1)) begin
        tmrTrig = 1'b1;
      end else begin
        tmrCnt_d = tmrCnt_q + TMR_W'(1);
      end
    end
  end

  assign trig = host_trig | tmrTrig;
  assign busy = (state_q != ST_IDLE);

  // Snapshot FSM next state, plus the one-deep pending trigger and the
  // saturating overrun counter for triggers that arrive while busy.
  always_comb begin
    state_d   = state_q;
    copyIdx_d = copyIdx_q;
    pending_d = pending_q;
    ovrCnt_d  = ovrCnt_q;
    case (state_q)
      ST_IDLE: begin
        if (trig || pending_q) begin
          state_d   = ST_LATCH;
          pending_d = 1'b0;
        end
      end
      ST_LATCH: begin
        state_d   = ST_COPY;
        copyIdx_d = '0;
      end
      ST_COPY: begin
        if (copyIdx_q == 4'(COPY_LEN - 1)) begin
          state_d = ST_SWAP;
        end else begin
          copyIdx_d = copyIdx_q + 4'd1;
        end
      end
      ST_SWAP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (busy && trig) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (ovrCnt_q != 8'hFF) begin
        ovrCnt_d = ovrCnt_q + 8'd1;
      end
    end
  end

  // Control registers. The bank flips and the sequence advances only in
  // SWAP, so a reset mid-sequence leaves no half-copied bank visible.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      copyIdx_q    <= '0;
      pending_q    <= 1'b0;
      ovrCnt_q     <= '0;
      seqCnt_q     <= '0;
      activeBank_q <= 1'b0;
      tmrCnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      copyIdx_q <= copyIdx_d;
      pending_q <= pending_d;
      ovrCnt_q  <= ovrCnt_d;
      tmrCnt_q  <= tmrCnt_d;
      if (state_q == ST_SWAP) begin
        activeBank_q <= ~activeBank_q;
        seqCnt_q     <= seqCnt_q + SEQ_W'(1);
      end
    end
  end

  // Staging capture: all 12 live words in the single LATCH cycle, so the set
  // is coherent. Quad counts are zero-extended to 32 bits here.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      for (int i = 0; i < COPY_LEN; i++) stage_q[i] <= '0;
    end else if (state_q == ST_LATCH) begin
      for (int ch = 0; ch < NCH; ch++) begin
        stage_q[3*ch]   <= {{(32-QUAD_W){1'b0}}, quad_in[ch*QUAD_W +: QUAD_W]};
        stage_q[3*ch+1] <= perd_in[ch*32 +: 32];
        stage_q[3*ch+2] <= freq_in[ch*32 +: 32];
      end
    end
  end

  // Shadow banks: COPY writes one staged word per cycle into the bank that
  // readers are not currently looking at.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < COPY_LEN; i++) bank_q[b][i] <= '0;
      end
    end else if (state_q == ST_COPY) begin
      bank_q[~activeBank_q][copyIdx_q] <= stage_q[copyIdx_q];
    end
  end

  assign statusWord = {16'(seqCnt_q), ovrCnt_q, 6'b0, pending_q, busy};

  // Registered read port from the active bank or the live status word.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      rdData_q <= '0;
    end else if (rd_sel == RD_STATUS) begin
      rdData_q <= statusWord;
    end else begin
      rdData_q <= bank_q[activeBank_q][wordIndex(rd_ch, rd_sel)];
    end
  end

  assign rd_data = rdData_q;
  assign seq_cnt = seqCnt_q;
  assign ovr_cnt = ovrCnt_q;

  enc_preload_arb uArb (
    .sysclk    (sysclk),
    .reset     (reset),
    .hpReq_i   (hp_req),
    .hpCh_i    (hp_ch),
    .hpData_i  (hp_data),
    .axReq_i   (ax_req),
    .axCh_i    (ax_ch),
    .axData_i  (ax_data),
    .axAck_o   (ax_ack),
    .setEnc_o  (set_enc),
    .preload_o (preload)
  );

endmodule

// File: tb/tb_enc_snap_sched.sv
// tb_enc_snap_sched
// Directed self-checking bench for enc_snap_sched. Inputs are driven on the
// falling edge and outputs sampled on the next falling edge; k counts rising
// edges since a stimulus was applied.
module tb_enc_snap_sched;

  logic         sysclk;
  logic         reset;
  logic [99:0]  quad_in;
  logic [127:0] perd_in;
  logic [127:0] freq_in;
  logic         host_trig;
  logic [23:0]  tmr_period;
  logic [1:0]   rd_ch;
  logic [1:0]   rd_sel;
  logic [31:0]  rd_data;
  logic         busy;
  logic [15:0]  seq_cnt;
  logic [7:0]   ovr_cnt;
  logic         hp_req;
  logic [1:0]   hp_ch;
  logic [23:0]  hp_data;
  logic         ax_req;
  logic [1:0]   ax_ch;
  logic [23:0]  ax_data;
  logic         ax_ack;
  logic [3:0]   set_enc;
  logic [23:0]  preload;

  int checks = 0;
  int errors = 0;

  enc_snap_sched dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .quad_in    (quad_in),
    .perd_in    (perd_in),
    .freq_in    (freq_in),
    .host_trig  (host_trig),
    .tmr_period (tmr_period),
    .rd_ch      (rd_ch),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .busy       (busy),
    .seq_cnt    (seq_cnt),
    .ovr_cnt    (ovr_cnt),
    .hp_req     (hp_req),
    .hp_ch      (hp_ch),
    .hp_data    (hp_data),
    .ax_req     (ax_req),
    .ax_ch      (ax_ch),
    .ax_data    (ax_data),
    .ax_ack     (ax_ack),
    .set_enc    (set_enc),
    .preload    (preload)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic step();
    @(negedge sysclk);
  endtask

  // Hold reset low for two rising edges and return idle inputs.
  task automatic doReset();
    reset      = 1'b0;
    host_trig  = 1'b0;
    tmr_period = '0;
    hp_req     = 1'b0;
    ax_req     = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    quad_in = '0; perd_in = '0; freq_in = '0;
    rd_ch = 2'd0; rd_sel = 2'd3;
    hp_ch = '0; hp_data = '0; ax_ch = '0; ax_data = '0;
    doReset();
    step();
    checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_status got %h exp %h", rd_data, 32'h0); end
    checks++; if (preload !== 24'h800000) begin errors++; $display("[TB] FAIL reset_preload got %h exp %h", preload, 24'h800000); end
    checks++; if (set_enc !== 4'b0) begin errors++; $display("[TB] FAIL reset_set_enc got %b exp 0000", set_enc); end
    checks++; if ({busy, ax_ack, seq_cnt, ovr_cnt} !== 26'h0) begin errors++; $display("[TB] FAIL reset_misc got busy=%b ack=%b seq=%0d ovr=%0d", busy, ax_ack, seq_cnt, ovr_cnt); end
    rd_sel = 2'd0;
    step();
    checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_quad got %h exp 0", rd_data); end
  endtask

  task automatic test_snapshot();
    quad_in[25 +: 25] = 25'h0123456;
    quad_in[75 +: 25] = 25'h1000001;
    perd_in[32 +: 32] = 32'hDEADBEEF;
    freq_in[96 +: 32] = 32'h00C0FFEE;
    rd_ch = 2'd1; rd_sel = 2'd0;
    host_trig = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      host_trig = 1'b0;
      if (k == 5) quad_in[25 +: 25] = 25'h1555555;
      checks++; if (busy !== (k <= 14)) begin errors++; $display("[TB] FAIL snap_busy k=%0d got %b exp %b", k, busy, (k <= 14)); end
      if (k == 14 || k == 15) begin
        checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL snap_old_bank k=%0d got %h exp 0", k, rd_data); end
      end
      if (k == 14) begin
        checks++; if (seq_cnt !== 16'd0) begin errors++; $display("[TB] FAIL snap_seq_pre got %0d exp 0", seq_cnt); end
      end
    end
    checks++; if (seq_cnt !== 16'd1) begin errors++; $display("[TB] FAIL snap_seq got %0d exp 1", seq_cnt); end
    checks++; if (rd_data !== 32'h00123456) begin errors++; $display("[TB] FAIL snap_quad_ch2 got %h exp %h", rd_data, 32'h00123456); end
    rd_sel = 2'd1;
    step();
    checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL snap_perd_ch2 got %h exp %h", rd_data, 32'hDEADBEEF); end
    rd_ch = 2'd3; rd_sel = 2'd2;
    step();
    checks++; if (rd_data !== 32'h00C0FFEE) begin errors++; $display("[TB] FAIL snap_freq_ch4 got %h exp %h", rd_data, 32'h00C0FFEE); end
    rd_sel = 2'd0;
    step();
    checks++; if (rd_data !== 32'h01000001) begin errors++; $display("[TB] FAIL snap_quad_ch4_ovf got %h exp %h", rd_data, 32'h01000001); end
  endtask

  task automatic test_timer();
    doReset();
    tmr_period = 24'd100;
    for (int k = 1; k <= 220; k++) begin
      step();
      if (k == 99 || k == 199) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL tmr_idle k=%0d got %b exp 0", k, busy); end
      end
      if (k == 100 || k == 113 || k == 200) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL tmr_busy k=%0d got %b exp 1", k, busy); end
      end
      if (k == 113) begin
        checks++; if (seq_cnt !== 16'd0) begin errors++; $display("[TB] FAIL tmr_seq_113 got %0d exp 0", seq_cnt); end
      end
      if (k == 114) begin
        checks++; if ({busy, seq_cnt} !== {1'b0, 16'd1}) begin errors++; $display("[TB] FAIL tmr_swap1 got busy=%b seq=%0d exp busy=0 seq=1", busy, seq_cnt); end
      end
      if (k == 214) begin
        checks++; if (seq_cnt !== 16'd2) begin errors++; $display("[TB] FAIL tmr_swap2 got %0d exp 2", seq_cnt); end
      end
    end
    tmr_period = 24'd0;
    for (int k = 0; k < 300; k++) step();
    checks++; if ({busy, seq_cnt} !== {1'b0, 16'd2}) begin errors++; $display("[TB] FAIL tmr_disabled got busy=%b seq=%0d exp busy=0 seq=2", busy, seq_cnt); end
  endtask

  task automatic test_back_to_back();
    doReset();
    rd_ch = 2'd0; rd_sel = 2'd3;
    host_trig = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      step();
      host_trig = (k == 3 || k == 5 || k == 7);
      if (k == 12) begin
        checks++; if (rd_data !== 32'h00000203) begin errors++; $display("[TB] FAIL b2b_status_busy got %h exp %h", rd_data, 32'h00000203); end
      end
      if (k == 15) begin
        checks++; if ({busy, seq_cnt} !== {1'b0, 16'd1}) begin errors++; $display("[TB] FAIL b2b_gap got busy=%b seq=%0d exp busy=0 seq=1", busy, seq_cnt); end
      end
      if (k == 16) begin
        checks++; if (rd_data !== 32'h00010202) begin errors++; $display("[TB] FAIL b2b_status_pend got %h exp %h", rd_data, 32'h00010202); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart got %b exp 1", busy); end
      end
      if (k == 17) begin
        checks++; if (rd_data !== 32'h00010201) begin errors++; $display("[TB] FAIL b2b_status_clr got %h exp %h", rd_data, 32'h00010201); end
      end
      if (k == 30) begin
        checks++; if ({busy, seq_cnt, ovr_cnt} !== {1'b0, 16'd2, 8'd2}) begin errors++; $display("[TB] FAIL b2b_end got busy=%b seq=%0d ovr=%0d exp 0/2/2", busy, seq_cnt, ovr_cnt); end
      end
    end
    checks++; if (rd_data !== 32'h00020200) begin errors++; $display("[TB] FAIL b2b_status_end got %h exp %h", rd_data, 32'h00020200); end
  endtask

  task automatic test_preload_arb();
    hp_req = 1'b1; hp_ch = 2'd2; hp_data = 24'h000010;
    ax_req = 1'b1; ax_ch = 2'd0; ax_data = 24'h0000AA;
    step();
    hp_req = 1'b0;
    checks++; if ({set_enc, preload, ax_ack} !== {4'b0100, 24'h000010, 1'b0}) begin errors++; $display("[TB] FAIL arb_host got set=%b pre=%h ack=%b exp 0100/000010/0", set_enc, preload, ax_ack); end
    step();
    checks++; if ({set_enc, preload, ax_ack} !== {4'b0001, 24'h0000AA, 1'b1}) begin errors++; $display("[TB] FAIL arb_aux got set=%b pre=%h ack=%b exp 0001/0000aa/1", set_enc, preload, ax_ack); end
    step();
    ax_req = 1'b0;
    checks++; if ({set_enc, preload, ax_ack} !== {4'b0000, 24'h0000AA, 1'b0}) begin errors++; $display("[TB] FAIL arb_no_regrant got set=%b pre=%h ack=%b exp 0000/0000aa/0", set_enc, preload, ax_ack); end
    step();
    checks++; if ({set_enc, preload, ax_ack} !== {4'b0000, 24'h0000AA, 1'b0}) begin errors++; $display("[TB] FAIL arb_hold got set=%b pre=%h ack=%b exp 0000/0000aa/0", set_enc, preload, ax_ack); end
    hp_req = 1'b1; hp_ch = 2'd3; hp_data = 24'h123456;
    ax_req = 1'b1; ax_ch = 2'd1; ax_data = 24'h00BEEF;
    step();
    hp_ch = 2'd1; hp_data = 24'h000777;
    checks++; if ({set_enc, ax_ack} !== {4'b1000, 1'b0}) begin errors++; $display("[TB] FAIL arb_host_ch4 got set=%b ack=%b exp 1000/0", set_enc, ax_ack); end
    step();
    hp_req = 1'b0;
    checks++; if ({set_enc, preload, ax_ack} !== {4'b0010, 24'h000777, 1'b0}) begin errors++; $display("[TB] FAIL arb_host_again got set=%b pre=%h ack=%b exp 0010/000777/0", set_enc, preload, ax_ack); end
    step();
    checks++; if ({set_enc, preload, ax_ack} !== {4'b0010, 24'h00BEEF, 1'b1}) begin errors++; $display("[TB] FAIL arb_aux_late got set=%b pre=%h ack=%b exp 0010/00beef/1", set_enc, preload, ax_ack); end
    step();
    ax_req = 1'b0;
  endtask

  task automatic test_reset_mid_copy();
    doReset();
    rd_ch = 2'd1; rd_sel = 2'd0;
    quad_in[25 +: 25] = 25'h0000777;
    host_trig = 1'b1;
    for (int k = 1; k <= 16; k++) begin step(); host_trig = 1'b0; end
    checks++; if (rd_data !== 32'h00000777) begin errors++; $display("[TB] FAIL mid_first got %h exp %h", rd_data, 32'h00000777); end
    quad_in[25 +: 25] = 25'h0000999;
    host_trig = 1'b1;
    for (int k = 1; k <= 7; k++) begin step(); host_trig = 1'b0; end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++; if ({busy, seq_cnt, preload} !== {1'b0, 16'd0, 24'h800000}) begin errors++; $display("[TB] FAIL mid_abort got busy=%b seq=%0d pre=%h exp 0/0/800000", busy, seq_cnt, preload); end
    step();
    step();
    checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL mid_cleared got %h exp 0", rd_data); end
    host_trig = 1'b1;
    for (int k = 1; k <= 16; k++) begin step(); host_trig = 1'b0; end
    checks++; if ({seq_cnt, rd_data} !== {16'd1, 32'h00000999}) begin errors++; $display("[TB] FAIL mid_recover got seq=%0d data=%h exp 1/00000999", seq_cnt, rd_data); end
  endtask

  initial begin
    reset = 1'b0;
    host_trig = 1'b0; tmr_period = '0; hp_req = 1'b0; ax_req = 1'b0;
    test_reset();
    test_snapshot();
    test_timer();
    test_back_to_back();
    test_preload_arb();
    test_reset_mid_copy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
